// File: rtl/bcd_stopwatch_if.sv
// Control pulses and display/status outputs of the MM:SS stopwatch.
// The controller side is master; the stopwatch itself is slave.
interface bcd_stopwatch_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       running;
    logic       lap_hold;
    logic       sec_tick;
    logic       wrapped;

    modport master (
        output start_stop, clear, lap,
        input  d0, d1, d2, d3, running, lap_hold, sec_tick, wrapped
    );

    modport slave (
        input  start_stop, clear, lap,
        output d0, d1, d2, d3, running, lap_hold, sec_tick, wrapped
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// Count-up MM:SS stopwatch with start/stop, clear and lap-freeze, emitting BCD
// digits for the 7-segment scan path.
module bcd_stopwatch #(
    parameter  int TICK_DIV = 100000000,
    localparam int PW       = $clog2(TICK_DIV)
) (
    input  logic           clk,
    input  logic           reset,
    bcd_stopwatch_if.slave sw
);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_e;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } mmss_t;

    state_e        state_q;
    logic [PW-1:0] pre_q;
    mmss_t         cnt_q;
    mmss_t         lap_q;
    logic          lap_hold_q;
    logic          sec_tick_q;
    logic          wrapped_q;

    mmss_t         cnt_d;
    logic          wrap_d;
    logic          tick;
    mmss_t         disp;

    assign tick = (state_q == RUNNING) && (pre_q == PW'(TICK_DIV - 1));

    // NOTE: every output of an always_comb gets a default first so no path
    // through the if-chain leaves a value undriven, which would infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (cnt_q.d0 != 4'd9) begin
            cnt_d.d0 = cnt_q.d0 + 4'd1;
        end else begin
            cnt_d.d0 = 4'd0;
            if (cnt_q.d1 != 4'd5) begin
                cnt_d.d1 = cnt_q.d1 + 4'd1;
            end else begin
                cnt_d.d1 = 4'd0;
                if (cnt_q.d2 != 4'd9) begin
                    cnt_d.d2 = cnt_q.d2 + 4'd1;
                end else begin
                    cnt_d.d2 = 4'd0;
                    if (cnt_q.d3 != 4'd5) begin
                        cnt_d.d3 = cnt_q.d3 + 4'd1;
                    end else begin
                        cnt_d.d3 = 4'd0;
                        wrap_d   = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, e.g. the lap register captures the count before this
    // edge's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STOPPED;
            pre_q      <= '0;
            cnt_q      <= '0;
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
            sec_tick_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else if (sw.clear) begin
            state_q    <= STOPPED;
            pre_q      <= '0;
            cnt_q      <= '0;
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
            sec_tick_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            // The prescaler wraps even when a simultaneous stop drops the tick.
            if (state_q == RUNNING) begin
                pre_q <= tick ? '0 : pre_q + PW'(1);
            end
            if (sw.start_stop) begin
                state_q <= (state_q == RUNNING) ? STOPPED : RUNNING;
            end else if (tick) begin
                cnt_q      <= cnt_d;
                sec_tick_q <= 1'b1;
                if (wrap_d) begin
                    wrapped_q <= 1'b1;
                end
            end
            if (sw.lap) begin
                if (lap_hold_q) begin
                    lap_hold_q <= 1'b0;
                end else if (state_q == RUNNING) begin
                    lap_q      <= cnt_q;
                    lap_hold_q <= 1'b1;
                end
            end
        end
    end

    assign disp        = lap_hold_q ? lap_q : cnt_q;
    assign sw.d0       = disp.d0;
    assign sw.d1       = disp.d1;
    assign sw.d2       = disp.d2;
    assign sw.d3       = disp.d3;
    assign sw.running  = (state_q == RUNNING);
    assign sw.lap_hold = lap_hold_q;
    assign sw.sec_tick = sec_tick_q;
    assign sw.wrapped  = wrapped_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with TICK_DIV = 4; each step is
// sampled 1 ns after the rising edge.
module tb_bcd_stopwatch;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [15:0] disp;

    bcd_stopwatch_if sw ();

    bcd_stopwatch #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw.slave)
    );

    assign disp = {sw.d3, sw.d2, sw.d1, sw.d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ss();
        sw.start_stop = 1'b1;
        step(1);
        sw.start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        sw.lap = 1'b1;
        step(1);
        sw.lap = 1'b0;
    endtask

    task automatic pulse_clear();
        sw.clear = 1'b1;
        step(1);
        sw.clear = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_disp", disp, 16'h0000);
        check("rst_running", sw.running, 1'b0);
        check("rst_lap_hold", sw.lap_hold, 1'b0);
        check("rst_sec_tick", sw.sec_tick, 1'b0);
        check("rst_wrapped", sw.wrapped, 1'b0);

        // Run 10 seconds: increments on every 4th edge after the start edge.
        pulse_ss();
        check("run_running", sw.running, 1'b1);
        check("run_disp0", disp, 16'h0000);
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check("run_sec_tick", sw.sec_tick, (i % 4 == 0));
        end
        check("run_disp10", disp, 16'h0010);
        check("run_running2", sw.running, 1'b1);

        // Advance 3588 seconds to 59:58, then roll over.
        step(14352);
        check("pre_5958", disp, 16'h5958);
        check("pre_wrapped", sw.wrapped, 1'b0);
        step(4);
        check("disp_5959", disp, 16'h5959);
        check("wrap_flag0", sw.wrapped, 1'b0);
        step(4);
        check("disp_wrap", disp, 16'h0000);
        check("wrap_flag1", sw.wrapped, 1'b1);
        check("wrap_sec_tick", sw.sec_tick, 1'b1);
        step(4);
        check("disp_0001", disp, 16'h0001);
        check("wrap_sticky", sw.wrapped, 1'b1);

        // Pause with prescaler at 2, idle, lap ignored while stopped, resume.
        step(1);
        pulse_ss();
        check("stop_running", sw.running, 1'b0);
        step(20);
        check("stop_disp", disp, 16'h0001);
        check("stop_sec_tick", sw.sec_tick, 1'b0);
        pulse_lap();
        check("stop_lap_ignored", sw.lap_hold, 1'b0);
        pulse_ss();
        check("resume_running", sw.running, 1'b1);
        check("resume_disp", disp, 16'h0001);
        step(1);
        check("resume_disp_b", disp, 16'h0001);
        check("resume_no_tick", sw.sec_tick, 1'b0);
        step(1);
        check("resume_incr", disp, 16'h0002);
        check("resume_sec_tick", sw.sec_tick, 1'b1);

        // Lap freeze at 00:05 while the live count advances to 00:08.
        step(12);
        check("lap_pre", disp, 16'h0005);
        pulse_lap();
        check("lap_hold1", sw.lap_hold, 1'b1);
        check("lap_disp", disp, 16'h0005);
        step(12);
        check("lap_frozen", disp, 16'h0005);
        check("lap_hold_still", sw.lap_hold, 1'b1);
        pulse_lap();
        check("lap_release", sw.lap_hold, 1'b0);
        check("lap_live", disp, 16'h0008);

        // Clear on a tick cycle at 00:09.
        step(2);
        check("clr_pre", disp, 16'h0009);
        step(3);
        sw.lap = 1'b1;
        pulse_clear();
        sw.lap = 1'b0;
        check("clr_disp", disp, 16'h0000);
        check("clr_running", sw.running, 1'b0);
        check("clr_sec_tick", sw.sec_tick, 1'b0);
        check("clr_wrapped", sw.wrapped, 1'b0);
        check("clr_lap_hold", sw.lap_hold, 1'b0);

        // start_stop and clear together always land in STOPPED.
        sw.start_stop = 1'b1;
        pulse_clear();
        sw.start_stop = 1'b0;
        check("both_stopped", sw.running, 1'b0);
        pulse_ss();
        step(2);
        sw.start_stop = 1'b1;
        pulse_clear();
        sw.start_stop = 1'b0;
        check("both_running", sw.running, 1'b0);
        check("both_disp", disp, 16'h0000);

        // Stop on a tick cycle drops the tick and wraps the prescaler.
        pulse_ss();
        step(3);
        pulse_ss();
        check("drop_running", sw.running, 1'b0);
        check("drop_disp", disp, 16'h0000);
        check("drop_sec_tick", sw.sec_tick, 1'b0);
        pulse_ss();
        step(3);
        check("drop_full_sec", disp, 16'h0000);
        step(1);
        check("drop_incr", disp, 16'h0001);

        // Lap on a tick cycle captures the pre-increment count.
        step(3);
        pulse_lap();
        check("laptick_disp", disp, 16'h0001);
        check("laptick_sec_tick", sw.sec_tick, 1'b1);
        step(1);

        // Reset mid-run with display frozen.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst2_disp", disp, 16'h0000);
        check("rst2_running", sw.running, 1'b0);
        check("rst2_lap_hold", sw.lap_hold, 1'b0);
        check("rst2_sec_tick", sw.sec_tick, 1'b0);
        pulse_ss();
        step(3);
        check("rst2_partial", disp, 16'h0000);
        step(1);
        check("rst2_resume", disp, 16'h0001);
        check("rst2_sec_tick2", sw.sec_tick, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
